// File: rtl/note_sequencer.sv
// note_sequencer: plays a stream of 16-bit score words as timed notes.
//
// Score word: [15:14] mode, [13:8] tone, [7:0] BPM (mode 11) or [3:0] length.
//   mode 00 NORMAL, 01 STACCATO, 10 SLURRED, 11 tempo command.
// A note of length L lasts 4*L 64th-note ticks. Ticks come from a 32-bit
// accumulator that adds bpm each running cycle and wraps at CLK_HZ*15/4.
//
// Ports:
//   CLK         system clock, rising edge
//   Reset       synchronous active-high reset
//   play        run enable; low pauses a sounding note
//   word_valid  word_data is valid
//   word_data   score word
//   word_ready  a word is accepted this cycle (idle, playing, not in reset)
//   tone        tone index for the tone generator (holds while idle)
//   vol         volume, 0 = silent (registered)
//   bpm         current tempo
//   note_done   one-cycle pulse at the end of each note
//   busy        high while a note is sounding
//
// Build option: define SEQ_DECAY_EN to make the level decay by one per tick
// (floored at 4) instead of staying at VOL_MAX.
module note_sequencer #(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter logic [3:0]  VOL_MAX  = 4'd15,
  parameter logic [7:0]  BPM_INIT = 8'd80
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        play,
  input  logic        word_valid,
  input  logic [15:0] word_data,
  output logic        word_ready,
  output logic [5:0]  tone,
  output logic [3:0]  vol,
  output logic [7:0]  bpm,
  output logic        note_done,
  output logic        busy
);

  localparam logic [31:0] Limit = 32'((64'(CLK_HZ) * 64'd15) / 64'd4);

  typedef enum logic {StIdle, StSound} state_e;

  state_e      state_q;
  logic [1:0]  mode_q;
  logic [3:0]  len_q;
  logic [5:0]  ticks_q;
  logic [31:0] acc_q;

  logic [32:0] sum;
  logic        tick;
  logic [31:0] acc_next;
  logic [5:0]  ticks_next;
  logic [3:0]  level_next;
  logic        accept;
  logic [3:0]  word_len;

  // Gate expressed on remaining ticks R = 4L - E:
  // NORMAL E < 4L-1 <=> R > 1; STACCATO E < 2L <=> R > 2L.
  function automatic logic gate_on(input logic [1:0] mode, input logic [3:0] len,
                                   input logic [5:0] ticks);
    logic on;
    case (mode)
      2'b00:   on = (ticks > 6'd1);
      2'b01:   on = (ticks > {1'b0, len, 1'b0});
      default: on = 1'b1;
    endcase
    return on;
  endfunction

  assign word_ready = (state_q == StIdle) && play && !Reset;
  assign accept     = word_valid && word_ready;
  assign word_len   = word_data[3:0];
  assign busy       = (state_q == StSound);

  assign sum        = {1'b0, acc_q} + 33'(bpm);
  assign tick       = (state_q == StSound) && play && (sum >= {1'b0, Limit});
  assign acc_next   = tick ? 32'(sum - {1'b0, Limit}) : sum[31:0];
  assign ticks_next = ticks_q - 6'(tick);

`ifdef SEQ_DECAY_EN
  logic [3:0] level_q;
  assign level_next = (tick && (level_q > 4'd4)) ? level_q - 4'd1 : level_q;
`else
  assign level_next = VOL_MAX;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= StIdle;
      bpm       <= BPM_INIT;
      tone      <= 6'd0;
      vol       <= 4'd0;
      note_done <= 1'b0;
      acc_q     <= 32'd0;
      ticks_q   <= 6'd0;
      mode_q    <= 2'b00;
      len_q     <= 4'd0;
`ifdef SEQ_DECAY_EN
      level_q   <= VOL_MAX;
`endif
    end else begin
      note_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          vol <= 4'd0;
          if (accept) begin
            if (word_data[15:14] == 2'b11) begin
              if (word_data[7:0] != 8'd0) bpm <= word_data[7:0];
            end else if (word_len != 4'd0) begin
              tone    <= word_data[13:8];
              mode_q  <= word_data[15:14];
              len_q   <= word_len;
              ticks_q <= {word_len, 2'b00};
              acc_q   <= 32'd0;
              state_q <= StSound;
              // Every mode gates on at E = 0; a rest stays silent.
              vol     <= (word_data[13:8] != 6'd0) ? VOL_MAX : 4'd0;
`ifdef SEQ_DECAY_EN
              level_q <= VOL_MAX;
`endif
            end
          end
        end
        StSound: begin
          if (play) begin
            acc_q   <= acc_next;
            ticks_q <= ticks_next;
`ifdef SEQ_DECAY_EN
            level_q <= level_next;
`endif
            if (tick && (ticks_q == 6'd1)) begin
              state_q   <= StIdle;
              note_done <= 1'b1;
              vol       <= 4'd0;
            end else begin
              vol <= ((tone != 6'd0) && gate_on(mode_q, len_q, ticks_next)) ?
                     level_next : 4'd0;
            end
          end else begin
            vol <= 4'd0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
